// File: rtl/template_mc_accumulator.sv
// -----------------------------------------------------------------------------
// template_mc_accumulator
//
// Multi-channel sample forwarder / accumulator. Each channel either forwards
// every enabled sample (mode 0) or sums ACC_LENGTH enabled samples and emits
// the sum (mode 1). Finished per-channel results wait in a one-deep result
// slot. A round-robin arbiter moves them into a single registered
// valid/ready output stage, and each result is tagged with its channel index.
//
// Ports:
//   clk                in   single clock, rising edge
//   reset              in   asynchronous, active-low reset
//   input_data         in   NUM_CHANNELS packed signed samples, ch c at
//                           [c*DATA_WIDTH +: DATA_WIDTH]
//   enable             in   per-channel sample strobe
//   mode               in   0 = pass-through, 1 = accumulate-and-dump
//   overflow_clear     in   pulse, clears all sticky overflow bits
//   output_data        out  signed result, OUT_WIDTH bits
//   output_channel     out  channel index of output_data
//   output_data_valid  out  output register holds a result
//   output_data_ready  in   consumer accepts when high together with valid
//   overflow           out  sticky per-channel lost-result flags
// -----------------------------------------------------------------------------
module template_mc_accumulator #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int ACC_LENGTH   = 8,
  parameter int OUT_WIDTH    = DATA_WIDTH + $clog2(ACC_LENGTH),
  parameter int CH_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] input_data,
  input  logic [NUM_CHANNELS-1:0]            enable,
  input  logic                               mode,
  input  logic                               overflow_clear,
  output logic [OUT_WIDTH-1:0]               output_data,
  output logic [CH_WIDTH-1:0]                output_channel,
  output logic                               output_data_valid,
  input  logic                               output_data_ready,
  output logic [NUM_CHANNELS-1:0]            overflow
);

  localparam int CNT_WIDTH = $clog2(ACC_LENGTH);
  localparam int EXT_WIDTH = OUT_WIDTH - DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(ACC_LENGTH - 1);
  localparam logic [CH_WIDTH-1:0]  LAST_CH    = CH_WIDTH'(NUM_CHANNELS - 1);

  // Registered state
  logic                    r_mode;
  logic [OUT_WIDTH-1:0]    r_acc    [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]    r_cnt    [NUM_CHANNELS];
  logic [OUT_WIDTH-1:0]    r_result [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_pending;
  logic [NUM_CHANNELS-1:0] r_overflow;
  logic [CH_WIDTH-1:0]     r_ptr;
  logic [OUT_WIDTH-1:0]    r_outData;
  logic [CH_WIDTH-1:0]     r_outChannel;
  logic                    r_outValid;

  // Combinational next-state signals
  logic                    w_modeChange;
  logic [OUT_WIDTH-1:0]    w_sampleExt [NUM_CHANNELS];
  logic [OUT_WIDTH-1:0]    w_accBase   [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]    w_cntBase   [NUM_CHANNELS];
  logic [OUT_WIDTH-1:0]    w_accNext   [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]    w_cntNext   [NUM_CHANNELS];
  logic [OUT_WIDTH-1:0]    w_newValue  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] w_newResult;

  logic                    w_loadOut;
  logic                    w_grantValid;
  logic [CH_WIDTH-1:0]     w_grantIdx;
  logic [CH_WIDTH-1:0]     w_cand;
  logic [CH_WIDTH-1:0]     w_ptrNext;
  logic [NUM_CHANNELS-1:0] w_granted;
  logic [NUM_CHANNELS-1:0] w_pendingNext;
  logic [NUM_CHANNELS-1:0] w_overflowSet;
  logic [NUM_CHANNELS-1:0] w_overflowNext;

  // Sign-extend every channel's sample to the full accumulator width.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : gen_ext
    logic [DATA_WIDTH-1:0] w_raw;
    assign w_raw          = input_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_sampleExt[g] = {{EXT_WIDTH{w_raw[DATA_WIDTH-1]}}, w_raw};
  end

  // Per-channel datapath. In a mode-change cycle the accumulator and counter
  // are treated as zero, so that cycle's sample starts from fresh state and
  // any partial sum is dropped. In pass-through mode the accumulator is kept
  // cleared.
  always_comb begin
    w_modeChange = (mode != r_mode);
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_accBase[c]   = w_modeChange ? '0 : r_acc[c];
      w_cntBase[c]   = w_modeChange ? '0 : r_cnt[c];
      w_accNext[c]   = w_accBase[c];
      w_cntNext[c]   = w_cntBase[c];
      w_newValue[c]  = w_sampleExt[c];
      w_newResult[c] = 1'b0;
      if (enable[c]) begin
        if (!mode) begin
          w_newResult[c] = 1'b1;
          w_accNext[c]   = '0;
          w_cntNext[c]   = '0;
        end else if (w_cntBase[c] == LAST_COUNT) begin
          w_newResult[c] = 1'b1;
          w_newValue[c]  = w_accBase[c] + w_sampleExt[c];
          w_accNext[c]   = '0;
          w_cntNext[c]   = '0;
        end else begin
          w_accNext[c]   = w_accBase[c] + w_sampleExt[c];
          w_cntNext[c]   = w_cntBase[c] + 1'b1;
        end
      end
    end
  end

  // Round-robin arbiter. The scan starts at r_ptr, and the first pending
  // channel wins. A grant is only made when the output register can accept
  // new data: it is empty, or it is being emptied by a handshake this cycle.
  always_comb begin
    w_loadOut    = !r_outValid || output_data_ready;
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    w_cand       = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_cand = CH_WIDTH'((int'(r_ptr) + i) % NUM_CHANNELS);
      if (w_loadOut && !w_grantValid && r_pending[w_cand]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = w_cand;
      end
    end
    w_ptrNext = (w_grantIdx == LAST_CH) ? '0 : w_grantIdx + 1'b1;
  end

  // Pending/overflow bookkeeping. When a new result arrives for a channel
  // that is granted in the same cycle, the old value leaves through the
  // output and nothing is lost. When the channel is still waiting and is not
  // granted, the old value is overwritten and the loss is flagged. If an
  // overflow set and a clear happen in the same cycle, the set wins.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_granted[c]     = w_grantValid && (w_grantIdx == CH_WIDTH'(c));
      w_pendingNext[c] = w_newResult[c] | (r_pending[c] & ~w_granted[c]);
      w_overflowSet[c] = w_newResult[c] & r_pending[c] & ~w_granted[c];
    end
    w_overflowNext = (r_overflow & ~{NUM_CHANNELS{overflow_clear}}) | w_overflowSet;
  end

  // Per-channel state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode     <= 1'b0;
      r_pending  <= '0;
      r_overflow <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_acc[c]    <= '0;
        r_cnt[c]    <= '0;
        r_result[c] <= '0;
      end
    end else begin
      r_mode     <= mode;
      r_pending  <= w_pendingNext;
      r_overflow <= w_overflowNext;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_acc[c] <= w_accNext[c];
        r_cnt[c] <= w_cntNext[c];
        if (w_newResult[c]) begin
          r_result[c] <= w_newValue[c];
        end
      end
    end
  end

  // Output register and arbiter pointer. The output register holds its
  // contents until a handshake occurs. After a handshake with nothing
  // pending, valid drops and the stale data is left in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outData    <= '0;
      r_outChannel <= '0;
      r_outValid   <= 1'b0;
      r_ptr        <= '0;
    end else if (w_loadOut) begin
      if (w_grantValid) begin
        r_outData    <= r_result[w_grantIdx];
        r_outChannel <= w_grantIdx;
        r_outValid   <= 1'b1;
        r_ptr        <= w_ptrNext;
      end else begin
        r_outValid   <= 1'b0;
      end
    end
  end

  assign output_data       = r_outData;
  assign output_channel    = r_outChannel;
  assign output_data_valid = r_outValid;
  assign overflow          = r_overflow;

endmodule

// File: tb/tb_template_mc_accumulator.sv
// -----------------------------------------------------------------------------
// tb_template_mc_accumulator
//
// Self-checking bench for template_mc_accumulator. A behavioural model
// (integer sums, sample counts and per-channel result slots) is stepped once
// per clock edge and compared against the DUT every cycle. A set of directed
// scenarios with hand-computed literal expectations pins the model itself.
// Those scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_template_mc_accumulator;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int AL = 8;
  localparam int OW = DW + $clog2(AL);
  localparam int CW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC*DW-1:0] input_data;
  logic [NC-1:0]    enable;
  logic             mode;
  logic             overflow_clear;
  logic [OW-1:0]    output_data;
  logic [CW-1:0]    output_channel;
  logic             output_data_valid;
  logic             output_data_ready;
  logic [NC-1:0]    overflow;

  template_mc_accumulator #(
    .DATA_WIDTH(DW),
    .NUM_CHANNELS(NC),
    .ACC_LENGTH(AL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .input_data(input_data),
    .enable(enable),
    .mode(mode),
    .overflow_clear(overflow_clear),
    .output_data(output_data),
    .output_channel(output_channel),
    .output_data_valid(output_data_valid),
    .output_data_ready(output_data_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int passCount  = 0;
  int checkCount = 0;

  // Behavioural model state
  int      mAcc [NC];
  int      mCnt [NC];
  int      mRes [NC];
  bit      mPend [NC];
  int      mOutData;
  int      mOutCh;
  bit      mValid;
  int      mPtr;
  bit [NC-1:0] mOvf;
  bit      mMode;

  task automatic check(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int sampleOf(input int c);
    logic [DW-1:0] raw;
    raw = input_data[c*DW +: DW];
    return int'($signed(raw));
  endfunction

  task automatic setSample(input int c, input int v);
    input_data[c*DW +: DW] = DW'(v);
  endtask

  task automatic modelReset();
    for (int c = 0; c < NC; c++) begin
      mAcc[c] = 0; mCnt[c] = 0; mRes[c] = 0; mPend[c] = 0;
    end
    mOutData = 0; mOutCh = 0; mValid = 0; mPtr = 0; mOvf = '0; mMode = 0;
  endtask

  // One clock edge worth of model behaviour, using the inputs present at
  // the edge.
  task automatic modelStep();
    bit loadOut;
    int g;
    bit newRes [NC];
    int newVal [NC];
    int s;
    loadOut = !mValid || output_data_ready;
    g = -1;
    if (loadOut) begin
      for (int i = 0; i < NC; i++) begin
        int idx;
        idx = (mPtr + i) % NC;
        if (g < 0 && mPend[idx]) g = idx;
      end
    end
    for (int c = 0; c < NC; c++) begin
      newRes[c] = 0;
      newVal[c] = 0;
      if (mode != mMode) begin
        mAcc[c] = 0; mCnt[c] = 0;
      end
      if (enable[c]) begin
        s = sampleOf(c);
        if (!mode) begin
          newRes[c] = 1; newVal[c] = s; mAcc[c] = 0; mCnt[c] = 0;
        end else begin
          mAcc[c] += s;
          mCnt[c]++;
          if (mCnt[c] == AL) begin
            newRes[c] = 1; newVal[c] = mAcc[c]; mAcc[c] = 0; mCnt[c] = 0;
          end
        end
      end
    end
    if (loadOut) begin
      if (g >= 0) begin
        mOutData = mRes[g]; mOutCh = g; mValid = 1; mPtr = (g + 1) % NC;
      end else begin
        mValid = 0;
      end
    end
    if (overflow_clear) mOvf = '0;
    for (int c = 0; c < NC; c++) begin
      if (newRes[c]) begin
        if (mPend[c] && c != g) mOvf[c] = 1'b1;
        mRes[c]  = newVal[c];
        mPend[c] = 1;
      end else if (c == g) begin
        mPend[c] = 0;
      end
    end
    mMode = mode;
  endtask

  task automatic checkOutput();
    check("valid", int'(output_data_valid), int'(mValid));
    if (mValid) begin
      check("data", int'($signed(output_data)), mOutData);
      check("channel", int'(output_channel), mOutCh);
    end
    check("overflow", int'(overflow), int'(mOvf));
  endtask

  // Advance one clock edge with the currently driven inputs, step the model,
  // then compare just after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    reset  = 1'b0;
    enable = '0;
    overflow_clear = 1'b0;
    #1;
    modelReset();
    checkOutput();
    check("rst_valid", int'(output_data_valid), 0);
    check("rst_data", int'(output_data), 0);
    check("rst_channel", int'(output_channel), 0);
    check("rst_overflow", int'(overflow), 0);
    @(posedge clk);
    #1;
    checkOutput();
    reset = 1'b1;
  endtask

  task automatic idle(input int n);
    enable = '0;
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    reset = 1'b0;
    input_data = '0;
    enable = '0;
    mode = 1'b0;
    overflow_clear = 1'b0;
    output_data_ready = 1'b1;
    modelReset();
    #2;
    doReset();
    idle(1);

    // Pass-through of one sample, two-cycle latency, one-cycle valid
    $display("[TB] pass-through");
    mode = 1'b0; output_data_ready = 1'b1;
    enable = 4'b0001; setSample(0, 16'h1234);
    applyStimulus();
    enable = '0;
    check("pt_early_valid", int'(output_data_valid), 0);
    applyStimulus();
    check("pt_valid", int'(output_data_valid), 1);
    check("pt_data", int'(output_data), 32'h01234);
    check("pt_channel", int'(output_channel), 0);
    applyStimulus();
    check("pt_valid_drop", int'(output_data_valid), 0);

    // Accumulate eight samples of -3 on channel 2
    $display("[TB] accumulate");
    doReset();
    mode = 1'b1;
    for (int i = 0; i < AL; i++) begin
      enable = 4'b0100; setSample(2, -3);
      applyStimulus();
      check("acc_no_early", int'(output_data_valid), 0);
    end
    enable = '0;
    applyStimulus();
    check("acc_valid", int'(output_data_valid), 1);
    check("acc_data_bits", int'(output_data), 32'h7FFE8);
    check("acc_data", int'($signed(output_data)), -24);
    check("acc_channel", int'(output_channel), 2);
    applyStimulus();
    check("acc_single", int'(output_data_valid), 0);

    // Round-robin ordering
    $display("[TB] round robin");
    doReset();
    mode = 1'b0;
    enable = 4'b1111;
    for (int c = 0; c < NC; c++) setSample(c, 100 + c);
    applyStimulus();
    enable = '0;
    for (int c = 0; c < NC; c++) begin
      applyStimulus();
      check("rr_channel", int'(output_channel), c);
      check("rr_data", int'($signed(output_data)), 100 + c);
    end
    applyStimulus();
    check("rr_drain", int'(output_data_valid), 0);
    enable = 4'b1010; setSample(1, 11); setSample(3, 33);
    applyStimulus();
    enable = '0;
    applyStimulus();
    check("rr2_first", int'(output_channel), 1);
    applyStimulus();
    check("rr2_second", int'(output_channel), 3);

    // Backpressure and overflow
    $display("[TB] backpressure");
    doReset();
    mode = 1'b0; output_data_ready = 1'b0;
    enable = 4'b0010; setSample(1, 5); applyStimulus();
    idle(1);
    enable = 4'b0010; setSample(1, 7); applyStimulus();
    check("bp_no_ovf_yet", int'(overflow), 0);
    enable = 4'b0010; setSample(1, 9); applyStimulus();
    enable = '0;
    check("bp_hold5", int'($signed(output_data)), 5);
    check("bp_ovf", int'(overflow), 4'b0010);
    idle(2);
    check("bp_still5", int'($signed(output_data)), 5);
    output_data_ready = 1'b1;
    applyStimulus();
    check("bp_then9", int'($signed(output_data)), 9);
    check("bp_valid9", int'(output_data_valid), 1);
    applyStimulus();
    check("bp_empty", int'(output_data_valid), 0);
    check("bp_ovf_sticky", int'(overflow), 4'b0010);
    overflow_clear = 1'b1; applyStimulus(); overflow_clear = 1'b0;
    check("bp_ovf_clear", int'(overflow), 0);

    // Reset in the middle of an accumulation
    $display("[TB] reset mid-operation");
    doReset();
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      enable = 4'b0001; setSample(0, 1); applyStimulus();
    end
    doReset();
    for (int i = 0; i < AL; i++) begin
      enable = 4'b0001; setSample(0, 1); applyStimulus();
      check("rm_no_early", int'(output_data_valid), 0);
    end
    enable = '0;
    applyStimulus();
    check("rm_data", int'($signed(output_data)), 8);
    check("rm_valid", int'(output_data_valid), 1);

    // Mode switch discards the partial sum
    $display("[TB] mode switch");
    doReset();
    mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enable = 4'b1000; setSample(3, 10); applyStimulus();
    end
    enable = '0;
    mode = 1'b0; applyStimulus();
    mode = 1'b1; applyStimulus();
    check("ms_no_partial", int'(output_data_valid), 0);
    for (int i = 0; i < AL; i++) begin
      enable = 4'b1000; setSample(3, 2); applyStimulus();
      check("ms_no_early", int'(output_data_valid), 0);
    end
    enable = '0;
    applyStimulus();
    check("ms_data", int'($signed(output_data)), 16);
    check("ms_channel", int'(output_channel), 3);

    // Randomized traffic against the model
    $display("[TB] random traffic");
    doReset();
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NC; c++) enable[c] = ($urandom_range(99) < 30);
      input_data = {$urandom, $urandom};
      if ($urandom_range(99) == 0) mode = ~mode;
      output_data_ready = ($urandom_range(99) < 70);
      overflow_clear = ($urandom_range(99) < 3);
      if (n == 1500) doReset();
      applyStimulus();
    end
    idle(2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/template_mc_accumulator.md
# template_mc_accumulator

Parametrised, multi-channel successor to the single-channel template datapath block. Takes NUM_CHANNELS independent sample streams with per-channel enables and, per a run-time mode, either forwards each sample or accumulates ACC_LENGTH samples per channel and dumps the sum. Results are serialised onto one valid/ready output stream by a round-robin arbiter tagged with the channel index. Sits between the data-interface driver and the result interface consumer in the processing chain.

## Interface
- DATA_WIDTH, 16, signed input sample width per channel
- NUM_CHANNELS, 4, number of input channels (≥2)
- ACC_LENGTH, 8, samples per accumulated result; power of two, ≥2
- OUT_WIDTH, DATA_WIDTH+$clog2(ACC_LENGTH), derived, output sample width
- CH_WIDTH, max(1,$clog2(NUM_CHANNELS)), derived, channel tag width
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- input_data  in  NUM_CHANNELS*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH], signed
- enable  in  NUM_CHANNELS  per-channel sample strobe
- mode  in  1  0 = pass-through, 1 = accumulate-and-dump; quasi-static
- overflow_clear  in  1  single-cycle pulse, clears all overflow bits
- output_data  out  OUT_WIDTH  signed result
- output_channel  out  CH_WIDTH  channel index of output_data
- output_data_valid  out  1  output holds a result
- output_data_ready  in  1  consumer accepts when high with valid
- overflow  out  NUM_CHANNELS  sticky per-channel lost-result flag

## Operation
- Reset (reset low, async): all accumulators, sample counters, result registers, pending bits, overflow, output_data, output_channel, output_data_valid = 0; registered mode copy = 0; arbiter pointer = channel 0 highest priority.
- Per channel c, on enable[c]:
  - mode 0: result[c] ← sign-extended sample; pending[c] ← 1.
  - mode 1: acc[c] += sign-extended sample; cnt[c]++. On the ACC_LENGTH-th sample: result[c] ← acc[c]+sample, acc[c] ← 0, cnt[c] ← 0, pending[c] ← 1.
- Accumulation is full-precision in OUT_WIDTH; no saturation, cannot overflow by construction.
- Mode change: in any cycle where mode ≠ registered mode, all acc/cnt are treated as zero; the sample that cycle is processed under the new mode with fresh state. Partial sums are discarded, never output. Pending results are unaffected.
- Output stage: one register (output_data, output_channel, output_data_valid). Loads when empty or when handshake (valid & ready) occurs that cycle; loads the pending channel chosen round-robin, clears its pending bit. Priority rotates to channel after last grant.
- valid stays high and data/channel stay stable until handshake.
- Result lost: new result for channel c while pending[c]=1 and c not granted this cycle → result[c] overwritten by newer value, overflow[c] ← 1.
- Simultaneous grant of c and new result for c: older value moves to output, newer stored, pending[c] stays 1, no overflow.
- overflow bits sticky until overflow_clear or reset; a set in the same cycle as clear wins (bit stays 1).

## Timing
- Final/only sample sampled at edge N → result/pending visible after N → output_data_valid high after edge N+1 (2-cycle latency) when output stage free.
- With ready held high, one result per cycle sustained; back-to-back handshakes allowed.
- No combinational path from inputs to outputs; output_data_ready only affects next-edge state.
- Sustained throughput across all channels limited to 1 result/cycle; excess in mode 0 sets overflow.

## Test plan
- Pass-through: reset, mode=0, ready=1, enable[0] one cycle with 16'h1234 → two edges later valid=1, output_data=19'h01234, channel=0, for exactly one cycle.
- Accumulate: mode=1, channel 2 fed eight samples of 16'hFFFD (−3) → no output for first seven; one output 19'h7FFE8 (−24), channel=2.
- Round robin: mode=0, all four enables same cycle, ready=1 → channels 0,1,2,3 on four consecutive cycles; then ch1 and ch3 together → order 1, 3.
- Backpressure/overflow: ready=0, mode=0, ch1 samples 5, 7, 9 on successive enables → output holds 5; 7 overwritten, overflow[1]=1; raise ready → outputs 5 then 9; overflow[1] stays 1 until overflow_clear pulse, then 0.
- Reset mid-operation: mode=1, five samples of 1 on ch0, pulse reset low, then eight samples of 1 → single output 8 (not 13); all outputs 0 during reset.
- Mode switch: mode=1, three samples of 10 on ch3, set mode=0 then back to 1, eight samples of 2 → no partial-sum output; final output 16.
